// File: rtl/frame_mode_sequencer_pkg.sv
// Shared types and constants for the frame-synchronous mode sequencer.
package frame_mode_pkg;
  localparam int MODE_W         = 3;
  localparam int MODE_EDGE_PATH = 0;
  localparam int MODE_EDGE_EN   = 1;
  localparam int MODE_HORIZ     = 2;
  localparam int DEB_W          = 16;
  localparam int LOAD_W         = 8;
  localparam int CHG_W          = 8;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_LOAD, S_SETTLE} state_t;
endpackage

// File: rtl/frame_mode_sequencer_debounce.sv
// Switch-vector debouncer: 2-flop synchronizer, held candidate and a
// stability counter. The output follows the candidate once it has been
// stable for P_DEB_CYC consecutive cycles.
module sw_debounce
  import frame_mode_pkg::*;
#(
  parameter int               W         = 3,
  parameter logic [DEB_W-1:0] P_DEB_CYC = 16'd50000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw,
  output logic [W-1:0] deb
);
  logic [W-1:0]     sync1, sync2, cand;
  logic [DEB_W-1:0] cnt;

  // Bring the asynchronous switches into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  // Any difference restarts the stability window; a full window commits
  // the candidate and the counter parks at its terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      cnt  <= '0;
      deb  <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= '0;
    end else if (cnt == P_DEB_CYC - 16'd1) begin
      deb  <= cand;
    end else begin
      cnt  <= cnt + 16'd1;
    end
  end
endmodule

// File: rtl/frame_mode_sequencer.sv
// Commits debounced mode-switch changes only at camera frame boundaries,
// then issues a reload pulse to the frame-buffer address loaders and blanks
// frame writes until the next frame begins.
module frame_mode_sequencer
  import frame_mode_pkg::*;
#(
  parameter logic [DEB_W-1:0]  P_DEB_CYC  = 16'd50000,
  parameter logic [LOAD_W-1:0] P_LOAD_CYC = 8'd16
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [MODE_W-1:0] iMODE_SW,
  input  logic              iFVAL,
  output logic [MODE_W-1:0] oMODE,
  output logic              oLOAD,
  output logic              oBLANK,
  output logic [CHG_W-1:0]  oCHG_CNT
);
  logic [MODE_W-1:0] deb;
  logic              fv_s1, fv_s2, fv_d;
  logic              frame_end, frame_start;
  state_t            state, state_n;
  logic [LOAD_W-1:0] ld_cnt, ld_n;
  logic [MODE_W-1:0] mode_n;
  logic [CHG_W-1:0]  chg_n;
  logic              load_n, blank_n;

  sw_debounce #(.W(MODE_W), .P_DEB_CYC(P_DEB_CYC)) u_deb (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .sw    (iMODE_SW),
    .deb   (deb)
  );

  // Synchronize frame-valid and keep one delayed copy for edge detection.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fv_s1 <= 1'b0;
      fv_s2 <= 1'b0;
      fv_d  <= 1'b0;
    end else begin
      fv_s1 <= iFVAL;
      fv_s2 <= fv_s1;
      fv_d  <= fv_s2;
    end
  end

  assign frame_end   = fv_d & ~fv_s2;
  assign frame_start = ~fv_d & fv_s2;

  // State, reload counter and all outputs are registered together.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= S_IDLE;
      ld_cnt   <= '0;
      oMODE    <= '0;
      oCHG_CNT <= '0;
      oLOAD    <= 1'b0;
      oBLANK   <= 1'b0;
    end else begin
      state    <= state_n;
      ld_cnt   <= ld_n;
      oMODE    <= mode_n;
      oCHG_CNT <= chg_n;
      oLOAD    <= load_n;
      oBLANK   <= blank_n;
    end
  end

  // Next state and next outputs. IDLE ignores frame edges, so a frame end
  // arriving on the IDLE->PEND step is not a commit point; LOAD/SETTLE do
  // not look at the debounced value, so changes there wait for IDLE.
  always_comb begin
    state_n = state;
    ld_n    = ld_cnt;
    mode_n  = oMODE;
    chg_n   = oCHG_CNT;
    case (state)
      S_IDLE:   if (deb != oMODE) state_n = S_PEND;
      S_PEND: begin
        if (deb == oMODE) begin
          state_n = S_IDLE;
        end else if (frame_end) begin
          state_n = S_LOAD;
          mode_n  = deb;
          chg_n   = oCHG_CNT + 8'd1;
          ld_n    = '0;
        end
      end
      S_LOAD: begin
        if (ld_cnt == P_LOAD_CYC - 8'd1) state_n = S_SETTLE;
        else                             ld_n    = ld_cnt + 8'd1;
      end
      S_SETTLE: if (frame_start) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    load_n  = (state_n == S_LOAD);
    blank_n = (state_n == S_LOAD) || (state_n == S_SETTLE);
  end
endmodule

// File: tb/tb_frame_mode_sequencer.sv
// Directed bench for frame_mode_sequencer with short debounce/reload windows.
module tb_frame_mode_sequencer;
  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic [2:0] iMODE_SW;
  logic       iFVAL;
  logic [2:0] oMODE;
  logic       oLOAD, oBLANK;
  logic [7:0] oCHG_CNT;

  int n_run  = 0;
  int n_fail = 0;

  frame_mode_sequencer #(.P_DEB_CYC(16'd4), .P_LOAD_CYC(8'd3)) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iMODE_SW (iMODE_SW),
    .iFVAL    (iFVAL),
    .oMODE    (oMODE),
    .oLOAD    (oLOAD),
    .oBLANK   (oBLANK),
    .oCHG_CNT (oCHG_CNT)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_run++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // All driving and sampling happens at the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  // Drop frame-valid and observe n cycles: number of load cycles, the
  // index of the first load cycle, and oMODE on that first load cycle.
  task automatic drop_watch(input int n, output int nload, output int first, output logic [2:0] m_at);
    nload = 0; first = -1; m_at = 3'b000;
    iFVAL = 1'b0;
    for (int i = 1; i <= n; i++) begin
      cyc(1);
      if (oLOAD) begin
        if (first < 0) begin first = i; m_at = oMODE; end
        nload++;
      end
    end
  endtask

  // One full commit cycle: change switches, debounce, frame end, frame start.
  task automatic commit_one(input logic [2:0] v);
    iMODE_SW = v;
    cyc(10);
    iFVAL = 1'b0;
    cyc(8);
    iFVAL = 1'b1;
    cyc(5);
  endtask

  int         nl, fi, tog_loads;
  logic [2:0] ma;

  initial begin
    iRST_N = 1'b0; iMODE_SW = 3'b000; iFVAL = 1'b1;
    cyc(3);
    chk("rst_mode",  oMODE, 3'b000);
    chk("rst_load",  oLOAD, 1'b0);
    chk("rst_blank", oBLANK, 1'b0);
    chk("rst_cnt",   oCHG_CNT, 8'd0);
    iRST_N = 1'b1;
    cyc(10);

    // Basic commit at frame end
    iMODE_SW = 3'b011;
    cyc(20);
    chk("t1_hold_mode",  oMODE, 3'b000);
    chk("t1_hold_cnt",   oCHG_CNT, 8'd0);
    chk("t1_hold_blank", oBLANK, 1'b0);
    drop_watch(12, nl, fi, ma);
    chk("t1_first_load", fi, 3);
    chk("t1_load_len",   nl, 3);
    chk("t1_mode_at_ld", ma, 3'b011);
    chk("t1_mode",       oMODE, 3'b011);
    chk("t1_cnt",        oCHG_CNT, 8'd1);
    chk("t1_blank",      oBLANK, 1'b1);
    cyc(30);
    chk("t1_blank_wait", oBLANK, 1'b1);
    iFVAL = 1'b1;
    cyc(5);
    chk("t1_unblank",    oBLANK, 1'b0);

    // Chattering bit0 never debounces, even across a frame end
    tog_loads = 0;
    for (int k = 0; k < 20; k++) begin
      iMODE_SW = k[0] ? 3'b011 : 3'b010;
      if (k == 10) iFVAL = 1'b0;
      if (k == 15) iFVAL = 1'b1;
      for (int j = 0; j < 2; j++) begin
        cyc(1);
        if (oLOAD) tog_loads++;
      end
    end
    iMODE_SW = 3'b011;
    iFVAL = 1'b1;
    cyc(10);
    chk("t2_mode",  oMODE, 3'b011);
    chk("t2_cnt",   oCHG_CNT, 8'd1);
    chk("t2_loads", tog_loads, 0);

    // Change and revert before frame end: no commit
    iMODE_SW = 3'b111;
    cyc(15);
    iMODE_SW = 3'b011;
    cyc(15);
    drop_watch(10, nl, fi, ma);
    chk("t3_loads", nl, 0);
    chk("t3_blank", oBLANK, 1'b0);
    iFVAL = 1'b1;
    cyc(5);
    chk("t3_mode", oMODE, 3'b011);
    chk("t3_cnt",  oCHG_CNT, 8'd1);

    // Change during SETTLE is deferred to the following frame end
    iMODE_SW = 3'b001;
    cyc(15);
    drop_watch(8, nl, fi, ma);
    chk("t4_mode1", oMODE, 3'b001);
    chk("t4_cnt1",  oCHG_CNT, 8'd2);
    iMODE_SW = 3'b101;
    cyc(15);
    chk("t4_settle_mode",  oMODE, 3'b001);
    chk("t4_settle_blank", oBLANK, 1'b1);
    iFVAL = 1'b1;
    cyc(15);
    chk("t4_frame_mode", oMODE, 3'b001);
    chk("t4_frame_blk",  oBLANK, 1'b0);
    drop_watch(10, nl, fi, ma);
    chk("t4_mode2", oMODE, 3'b101);
    chk("t4_cnt2",  oCHG_CNT, 8'd3);
    chk("t4_load2", nl, 3);
    iFVAL = 1'b1;
    cyc(5);

    // Reset on the 2nd reload cycle
    iMODE_SW = 3'b000;
    cyc(15);
    drop_watch(3, nl, fi, ma);
    chk("t5_load1", oLOAD, 1'b1);
    cyc(1);
    chk("t5_load2", oLOAD, 1'b1);
    iRST_N = 1'b0;
    #1;
    chk("t5_rst_mode",  oMODE, 3'b000);
    chk("t5_rst_load",  oLOAD, 1'b0);
    chk("t5_rst_blank", oBLANK, 1'b0);
    chk("t5_rst_cnt",   oCHG_CNT, 8'd0);
    iMODE_SW = 3'b010;
    iFVAL = 1'b1;
    cyc(3);
    iRST_N = 1'b1;
    cyc(20);
    chk("t5_pre_mode",  oMODE, 3'b000);
    chk("t5_pre_load",  oLOAD, 1'b0);
    drop_watch(10, nl, fi, ma);
    chk("t5_mode", oMODE, 3'b010);
    chk("t5_cnt",  oCHG_CNT, 8'd1);
    chk("t5_load", nl, 3);
    iFVAL = 1'b1;
    cyc(5);

    // 255 more commits: counter wraps silently to 0
    for (int k = 0; k < 255; k++) begin
      commit_one(k[0] ? 3'b110 : 3'b101);
      if (k == 253) chk("t6_cnt_255", oCHG_CNT, 8'd255);
    end
    chk("t6_cnt_wrap", oCHG_CNT, 8'd0);
    chk("t6_mode",     oMODE, 3'b101);
    chk("t6_blank",    oBLANK, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
